// File: rtl/fixed_mult_scheduler_pkg.sv
// Shared types and constants for the round-robin multiplier scheduler.
// Purely declarative: no logic, no latency, no flow control.
package fixed_mult_scheduler_pkg;

  localparam int STATS_WIDTH = 32;
  localparam int DEF_A_WIDTH = 16;
  localparam int DEF_B_WIDTH = 16;

  typedef logic signed [DEF_A_WIDTH-1:0]             op_a_t;
  typedef logic signed [DEF_B_WIDTH-1:0]             op_b_t;
  typedef logic signed [DEF_A_WIDTH+DEF_B_WIDTH-1:0] prod_t;

  // A single requester still needs a 1-bit id field.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fixed_mult.sv
// Signed full-precision multiplier datapath; combinational, no flow control.
// Product width is A+B, so most-negative squared never overflows.
module fixed_mult #(
  parameter int A_WIDTH = 16,
  parameter int B_WIDTH = 16
) (
  input  logic signed [A_WIDTH-1:0]         a_i,
  input  logic signed [B_WIDTH-1:0]         b_i,
  output logic signed [A_WIDTH+B_WIDTH-1:0] product_o
);

  assign product_o = a_i * b_i;

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter scanning circularly from ptr_i; zero latency.
// en_i low forces an all-zero grant; the pointer register lives in the parent.
module rr_arbiter
  import fixed_mult_scheduler_pkg::*;
#(
  parameter  int NUM_REQ  = 4,
  localparam int ID_WIDTH = id_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]  req_i,
  input  logic [ID_WIDTH-1:0] ptr_i,
  input  logic                en_i,
  output logic [NUM_REQ-1:0]  gnt_o,
  output logic [ID_WIDTH-1:0] gnt_idx_o,
  output logic                gnt_vld_o
);

  int                  wide;
  logic [ID_WIDTH-1:0] pos;
  logic                found;

  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    found     = 1'b0;
    wide      = 0;
    pos       = '0;
    if (en_i) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        wide = int'(ptr_i) + k;
        if (wide >= NUM_REQ) wide = wide - NUM_REQ;
        pos = ID_WIDTH'(wide);
        if (!found && req_i[pos]) begin
          found      = 1'b1;
          gnt_o[pos] = 1'b1;
          gnt_idx_o  = pos;
        end
      end
    end
    gnt_vld_o = found;
  end

endmodule

// File: rtl/fixed_mult_scheduler.sv
// One shared signed multiplier, round-robin over NUM_REQ lanes; 1-cycle latency, 1 result/cycle.
// Output stall blocks all grants; FIXED_MULT_SCHEDULER_STATS_EN adds per-lane grant counters.
module fixed_mult_scheduler
  import fixed_mult_scheduler_pkg::*;
#(
  parameter  int NUM_REQ    = 4,
  parameter  int IN_A_WIDTH = 16,
  parameter  int IN_B_WIDTH = 16,
  localparam int ID_WIDTH   = id_width(NUM_REQ),
  localparam int PROD_WIDTH = IN_A_WIDTH + IN_B_WIDTH
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NUM_REQ-1:0][IN_A_WIDTH-1:0]   req_a,
  input  logic [NUM_REQ-1:0][IN_B_WIDTH-1:0]   req_b,
  input  logic [NUM_REQ-1:0]                   req_valid,
  output logic [NUM_REQ-1:0]                   req_ready,
  output logic signed [PROD_WIDTH-1:0]         out_product,
  output logic [ID_WIDTH-1:0]                  out_id,
  output logic                                 out_valid,
  input  logic                                 out_ready
`ifdef FIXED_MULT_SCHEDULER_STATS_EN
  ,
  output logic [NUM_REQ-1:0][STATS_WIDTH-1:0]  grant_count
`endif
);

  typedef logic signed [IN_A_WIDTH-1:0] sched_a_t;
  typedef logic signed [IN_B_WIDTH-1:0] sched_b_t;
  typedef logic signed [PROD_WIDTH-1:0] sched_p_t;

  logic                slot_free;
  logic [NUM_REQ-1:0]  gnt;
  logic [ID_WIDTH-1:0] gnt_idx;
  logic                gnt_vld;
  sched_a_t            sel_a;
  sched_b_t            sel_b;
  sched_p_t            mult_p;

  logic [ID_WIDTH-1:0] ptr_q, ptr_d;
  logic                out_valid_q, out_valid_d;
  sched_p_t            out_product_q, out_product_d;
  logic [ID_WIDTH-1:0] out_id_q, out_id_d;

  assign slot_free = !out_valid_q || out_ready;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req_i     (req_valid),
    .ptr_i     (ptr_q),
    .en_i      (slot_free),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx),
    .gnt_vld_o (gnt_vld)
  );

  assign req_ready = gnt;
  assign sel_a     = req_a[gnt_idx];
  assign sel_b     = req_b[gnt_idx];

  fixed_mult #(.A_WIDTH(IN_A_WIDTH), .B_WIDTH(IN_B_WIDTH)) u_mult (
    .a_i       (sel_a),
    .b_i       (sel_b),
    .product_o (mult_p)
  );

  // A grant overrides a drain, so a stalled-then-released slot refills in the same cycle.
  always_comb begin
    ptr_d         = ptr_q;
    out_valid_d   = out_valid_q;
    out_product_d = out_product_q;
    out_id_d      = out_id_q;
    if (gnt_vld) begin
      out_valid_d   = 1'b1;
      out_product_d = mult_p;
      out_id_d      = gnt_idx;
      ptr_d         = (gnt_idx == ID_WIDTH'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q         <= '0;
      out_valid_q   <= 1'b0;
      out_product_q <= '0;
      out_id_q      <= '0;
    end else begin
      ptr_q         <= ptr_d;
      out_valid_q   <= out_valid_d;
      out_product_q <= out_product_d;
      out_id_q      <= out_id_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_product = out_product_q;
  assign out_id      = out_id_q;

`ifdef FIXED_MULT_SCHEDULER_STATS_EN
  logic [NUM_REQ-1:0][STATS_WIDTH-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (gnt[i]) cnt_q[i] <= cnt_q[i] + 1'b1;
      end
    end
  end

  assign grant_count = cnt_q;
`endif

endmodule

// File: tb/tb_fixed_mult_scheduler.sv
// Randomized bench for fixed_mult_scheduler against a spec-level reference model.
module tb_fixed_mult_scheduler;

  localparam int N = 4;

  logic               clk = 1'b0;
  logic               rst;
  logic [N-1:0][15:0] req_a;
  logic [N-1:0][15:0] req_b;
  logic [N-1:0]       req_valid;
  logic [N-1:0]       req_ready;
  logic signed [31:0] out_product;
  logic [1:0]         out_id;
  logic               out_valid;
  logic               out_ready;
`ifdef FIXED_MULT_SCHEDULER_STATS_EN
  logic [N-1:0][31:0] grant_count;
`endif

  int checks = 0;
  int errors = 0;

  bit         m_valid;
  longint     m_prod;
  int         m_id;
  int         m_ptr;
  int         m_cnt[N];
  logic [N-1:0] obs_ready;
  int         last_g;

  always #5 clk = ~clk;

  fixed_mult_scheduler #(.NUM_REQ(N), .IN_A_WIDTH(16), .IN_B_WIDTH(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_a       (req_a),
    .req_b       (req_b),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .out_product (out_product),
    .out_id      (out_id),
    .out_valid   (out_valid),
    .out_ready   (out_ready)
`ifdef FIXED_MULT_SCHEDULER_STATS_EN
    ,
    .grant_count (grant_count)
`endif
  );

  // Reference: who should win this cycle, from the circular-scan rule.
  function automatic int model_grant();
    if (m_valid && !out_ready) return -1;
    for (int k = 0; k < N; k++) begin
      if (req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] onehot(input int g);
    logic [N-1:0] v;
    v = '0;
    if (g >= 0) v[g] = 1'b1;
    return v;
  endfunction

  task automatic model_reset();
    m_valid = 0; m_prod = 0; m_id = 0; m_ptr = 0;
    for (int i = 0; i < N; i++) m_cnt[i] = 0;
  endtask

  // One clock: sample req_ready mid-cycle, advance model at the edge, settle 1 time unit.
  task automatic tick();
    @(negedge clk);
    last_g    = model_grant();
    obs_ready = req_ready;
    @(posedge clk);
    if (last_g >= 0) begin
      m_prod  = longint'($signed(req_a[last_g])) * longint'($signed(req_b[last_g]));
      m_id    = last_g;
      m_valid = 1;
      m_ptr   = (last_g + 1) % N;
      m_cnt[last_g]++;
    end else if (m_valid && out_ready) begin
      m_valid = 0;
    end
    #1;
  endtask

  task automatic randomize_operands();
    for (int i = 0; i < N; i++) begin
      req_a[i] = 16'($urandom);
      req_b[i] = 16'($urandom);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0; req_valid = '0; out_ready = 1'b0;
    randomize_operands();
    model_reset();
    #12;
    @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0; req_valid = '0; out_ready = 1'b0;
    randomize_operands();
    #7;
    checks++;
    if (out_valid !== 1'b0 || out_product !== 32'sd0 || out_id !== 2'd0) begin
      errors++;
      $display("FAIL reset_state: valid=%0b product=%0d id=%0d, required 0/0/0", out_valid, out_product, out_id);
    end
    do_reset();
    tick();
    checks++;
    if (out_valid !== 1'b0 || obs_ready !== 4'b0000) begin
      errors++;
      $display("FAIL reset_idle: valid=%0b ready=%b, required 0/0000", out_valid, obs_ready);
    end
  endtask

  task automatic test_single();
    do_reset();
    req_valid = 4'b0100; req_a[2] = 16'd3; req_b[2] = 16'hFFFB; out_ready = 1'b1;
    tick();
    checks++;
    if (obs_ready !== 4'b0100) begin
      errors++; $display("FAIL single_ready: got %b, required 0100", obs_ready);
    end
    checks++;
    if (out_valid !== 1'b1 || out_product !== -32'sd15 || out_id !== 2'd2) begin
      errors++;
      $display("FAIL single_result: valid=%0b product=%0d id=%0d, required 1/-15/2", out_valid, out_product, out_id);
    end
    req_valid = '0;
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL single_drain: valid=%0b, required 0", out_valid);
    end
  endtask

  task automatic test_rotation();
    do_reset();
    req_valid = 4'b1111; out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_id !== 2'(i % N) || longint'(out_product) !== m_prod) begin
        errors++;
        $display("FAIL rotation[%0d]: valid=%0b id=%0d product=%0d, required 1/%0d/%0d",
                 i, out_valid, out_id, out_product, i % N, m_prod);
      end
      randomize_operands();
    end
  endtask

  task automatic test_back_to_back_stall();
    logic signed [31:0] held_p;
    logic [1:0]         held_id;
    do_reset();
    req_valid = 4'b1111; out_ready = 1'b1;
    tick();
    held_p = out_product; held_id = out_id;
    checks++;
    if (held_id !== 2'd0 || longint'(held_p) !== m_prod) begin
      errors++; $display("FAIL stall_first: id=%0d product=%0d, required 0/%0d", held_id, held_p, m_prod);
    end
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      randomize_operands();
      tick();
      checks++;
      if (obs_ready !== 4'b0000 || out_valid !== 1'b1 || out_product !== held_p || out_id !== held_id) begin
        errors++;
        $display("FAIL stall_hold[%0d]: ready=%b valid=%0b id=%0d product=%0d, required 0000/1/%0d/%0d",
                 i, obs_ready, out_valid, out_id, out_product, held_id, held_p);
      end
    end
    out_ready = 1'b1;
    tick();
    checks++;
    if (obs_ready !== 4'b0010 || out_id !== 2'd1 || longint'(out_product) !== m_prod) begin
      errors++;
      $display("FAIL stall_release: ready=%b id=%0d product=%0d, required 0010/1/%0d", obs_ready, out_id, out_product, m_prod);
    end
  endtask

  task automatic test_extremes();
    do_reset();
    out_ready = 1'b1; req_valid = 4'b0001;
    req_a[0] = 16'h8000; req_b[0] = 16'h8000;
    tick();
    checks++;
    if (out_product !== 32'sd1073741824) begin
      errors++; $display("FAIL extreme_negneg: got %0d, required 1073741824", out_product);
    end
    req_a[0] = 16'h7FFF; req_b[0] = 16'h8000;
    tick();
    checks++;
    if (out_product !== -32'sd1073709056) begin
      errors++; $display("FAIL extreme_posneg: got %0d, required -1073709056", out_product);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    req_valid = 4'b1111; out_ready = 1'b0;
    tick();
    tick();
    #2 rst = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL async_reset: valid=%0b, required 0", out_valid);
    end
    model_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    out_ready = 1'b1;
    tick();
    checks++;
    if (obs_ready !== 4'b0001 || out_id !== 2'd0 || out_valid !== 1'b1) begin
      errors++; $display("FAIL reset_restart: ready=%b id=%0d valid=%0b, required 0001/0/1", obs_ready, out_id, out_valid);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      req_valid = 4'($urandom);
      out_ready = ($urandom_range(0, 9) < 7);
      randomize_operands();
      tick();
      checks++;
      if (obs_ready !== onehot(last_g)) begin
        errors++; $display("FAIL rand_ready[%0d]: got %b, required %b", c, obs_ready, onehot(last_g));
      end
      checks++;
      if (out_valid !== m_valid || (m_valid && (longint'(out_product) !== m_prod || int'(out_id) != m_id))) begin
        errors++;
        $display("FAIL rand_out[%0d]: valid=%0b id=%0d product=%0d, required %0b/%0d/%0d",
                 c, out_valid, out_id, out_product, m_valid, m_id, m_prod);
      end
`ifdef FIXED_MULT_SCHEDULER_STATS_EN
      for (int i = 0; i < N; i++) begin
        checks++;
        if (grant_count[i] !== 32'(m_cnt[i])) begin
          errors++; $display("FAIL rand_count[%0d][%0d]: got %0d, required %0d", c, i, grant_count[i], m_cnt[i]);
        end
      end
`endif
    end
  endtask

`ifdef FIXED_MULT_SCHEDULER_STATS_EN
  task automatic test_stats();
    int exp_cnt[N];
    exp_cnt = '{3, 3, 2, 2};
    do_reset();
    req_valid = 4'b1111; out_ready = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    req_valid = '0;
    tick();
    for (int i = 0; i < N; i++) begin
      checks++;
      if (grant_count[i] !== 32'(exp_cnt[i])) begin
        errors++; $display("FAIL stats_count[%0d]: got %0d, required %0d", i, grant_count[i], exp_cnt[i]);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_rotation();
    test_back_to_back_stall();
    test_extremes();
    test_reset_mid();
`ifdef FIXED_MULT_SCHEDULER_STATS_EN
    test_stats();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fixed_mult_scheduler.md
Name: fixed_mult_scheduler

Overview:
- Shares one signed fixed-point multiplier (the team's `fixed_mult` datapath) between NUM_REQ requesters.
- Arbitration is round-robin; each requester has its own valid/ready input channel.
- Every product is registered and returned on one shared valid/ready output channel, tagged with the requester index.
- Used wherever several small lanes need occasional multiplies but one DSP slice is budgeted.

Parameters:
- NUM_REQ, 4, number of requesters; legal range 1..16.
- IN_A_WIDTH, 16, operand A width (signed two's complement).
- IN_B_WIDTH, 16, operand B width (signed two's complement).
- ID_WIDTH, derived as max(1, $clog2(NUM_REQ)); not overridable.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous reset, active-low.
- req_a  input  [NUM_REQ][IN_A_WIDTH]  operand A per requester.
- req_b  input  [NUM_REQ][IN_B_WIDTH]  operand B per requester.
- req_valid  input  [NUM_REQ]  operands valid per requester.
- req_ready  output  [NUM_REQ]  one-hot or zero; that requester's operands are accepted this cycle.
- out_product  output  IN_A_WIDTH+IN_B_WIDTH  signed full-precision product.
- out_id  output  ID_WIDTH  index of the requester that owns out_product.
- out_valid  output  1  output register holds a result.
- out_ready  input  1  downstream accepts the result.

Behaviour:
- Reset (rst low, asynchronous): out_valid=0, out_product=0, out_id=0, rr pointer=0. Any in-flight result is discarded.
- Slot free condition: slot_free = !out_valid || out_ready.
- Grant selection:
  - If slot_free, grant the first index i with req_valid[i]=1, scanning circularly from the pointer (ptr, ptr+1, …, ptr-1).
  - req_ready[i]=1 only for the granted index. All others are 0.
  - If nothing is valid or the slot is not free, req_ready is all-zero.
- Combinational paths: req_ready depends combinationally on req_valid and out_ready. Requesters must not make req_valid depend on req_ready.
- On handshake (req_valid[g] && req_ready[g]):
  - out_product <= $signed(req_a[g]) * $signed(req_b[g]).
  - out_id <= g, out_valid <= 1.
  - ptr <= (g+1) mod NUM_REQ.
- Pointer hold: ptr is unchanged on any cycle without a grant.
- Output drain with no new grant (out_valid && out_ready): out_valid <= 0. Product and id registers hold their values.
- Simultaneous drain and grant: the new result replaces the old in the same cycle. Throughput is 1 result/cycle; latency is 1 cycle from handshake to out_valid.
- Backpressure (out_valid && !out_ready):
  - All req_ready are 0.
  - out_product and out_id stay stable until accepted.
- Fairness: with all requesters continuously valid and out_ready=1, grants rotate 0,1,…,NUM_REQ-1,0. No requester waits more than NUM_REQ-1 grants.
- Arithmetic: full-width product, no rounding or saturation. The most-negative × most-negative case is representable in the product width.
- NUM_REQ=1: ptr stays 0 and out_id is 0. The block degenerates to a registered multiplier with handshake.

Optional Feature:
- Macro: FIXED_MULT_SCHEDULER_STATS_EN.
- When defined:
  - Adds output port grant_count, [NUM_REQ][32].
  - Each per-requester counter increments on that requester's handshake and wraps at 2^32.
  - Counters reset to 0 asynchronously with rst.
- When undefined: the port and counters are absent; all other behaviour is identical.

Decomposition:
- Package fixed_mult_scheduler_pkg holds:
  - The ID_WIDTH computation function.
  - Typedefs for the operand and product types, parameterised through the module.
  - Constant STATS_WIDTH=32.
- Sub-module rr_arbiter (NUM_REQ parameter):
  - Inputs: request vector, pointer, enable.
  - Outputs: one-hot grant and encoded grant index.
  - Purely combinational; the pointer register lives in the parent.
- The multiply is done by instantiating fixed_mult, not by inline code.

Test Plan:
- Single requester: req 2 valid with a=3, b=-5, out_ready=1 -> req_ready[2]=1 that cycle; next cycle out_valid=1, out_product=-15, out_id=2.
- All four requesters continuously valid, out_ready=1 -> out_id sequence 0,1,2,3,0,1 on consecutive cycles with out_valid held 1.
- Backpressure: result held with out_ready=0 for 5 cycles while all requesters are valid -> req_ready all 0, out_product and out_id stable; on release, the next grant is the pointer's successor.
- Extremes (16-bit operands): a=-32768, b=-32768 -> out_product=1073741824. Also a=32767, b=-32768 -> -1073709056.
- Reset mid-operation: assert rst low while out_valid=1 -> out_valid=0 immediately (asynchronous); after release the first grant starts scanning from index 0.
- With FIXED_MULT_SCHEDULER_STATS_EN defined: 10 round-robin grants over 4 requesters -> grant_count = {3,3,2,2} for indices 0..3.
